// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the memory-stage load/store unit:
//   XLEN, RV32I load/store funct3 codes, mcause codes, FSM state encoding.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] MCAUSE_LOAD_MISALIGNED    = 4'd4;
  localparam logic [3:0] MCAUSE_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] MCAUSE_STORE_MISALIGNED   = 4'd6;
  localparam logic [3:0] MCAUSE_STORE_ACCESS_FAULT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_EXC  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Request/acknowledge bus between the LSU (master) and data_memory (slave).
//   mem_req        master->slave  request strobe, held until mem_ack
//   mem_addr       master->slave  byte address
//   mem_wdata      master->slave  store data
//   mem_funct3     master->slave  access width/sign code
//   mem_read_write master->slave  0 = load, 1 = store
//   mem_ack        slave->master  acknowledge, combinational from mem_req
//   mem_rdata      slave->master  load data, already width-extended
interface load_store_unit_if;
  logic                                  mem_req;
  logic [load_store_unit_pkg::XLEN-1:0]  mem_addr;
  logic [load_store_unit_pkg::XLEN-1:0]  mem_wdata;
  logic [2:0]                            mem_funct3;
  logic                                  mem_read_write;
  logic                                  mem_ack;
  logic [load_store_unit_pkg::XLEN-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_funct3, mem_read_write,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_funct3, mem_read_write,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_access_check.sv
// lsu_access_check
// Combinational width/alignment check for one load/store.
//   funct3, read_write, addr_lo  in   op width code, direction, addr[1:0]
//   legal                        out  width code valid for the direction
//   misaligned                   out  halfword/word not naturally aligned
//   cause                        out  mcause to report if the op traps
// Build option: LSU_MISALIGN_TRAP_EN enables the misalignment output;
// without it misaligned is tied low and data_memory sees the raw address.
module lsu_access_check
  import load_store_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       read_write,
  input  logic [1:0] addr_lo,
  output logic       legal,
  output logic       misaligned,
  output logic [3:0] cause
);

  always_comb begin
    if (read_write) legal = funct3 inside {F3_SB, F3_SH, F3_SW};
    else            legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0] encodes size for every legal code: 01 half, 10 word.
  always_comb begin
    misaligned = 1'b0;
    if (funct3[1:0] == 2'b01)      misaligned = addr_lo[0];
    else if (funct3[1:0] == 2'b10) misaligned = |addr_lo;
  end
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo;
  assign misaligned     = 1'b0;
`endif

  // Illegal width wins over misalignment.
  always_comb begin
    if (!legal) cause = read_write ? MCAUSE_STORE_ACCESS_FAULT : MCAUSE_LOAD_ACCESS_FAULT;
    else        cause = read_write ? MCAUSE_STORE_MISALIGNED   : MCAUSE_LOAD_MISALIGNED;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-stage LSU: accepts one load/store from execute, checks it, runs
// the data_memory handshake, then returns a writeback or exception pulse.
//   clk, i_rst_n            core clock, synchronous active-low reset
//   i_valid / o_ready       execute handshake; op accepted when both high
//   i_read_write, i_funct3, i_addr, i_store_data, i_rd   op fields
//   mem (master)            data_memory request/acknowledge bus
//   o_wb_valid, o_wb_we, o_wb_rd, o_wb_data   one-cycle completion
//   o_exc_valid, o_exc_cause, o_exc_tval      one-cycle exception
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_access_check).
//
// state | meaning
// IDLE  | no op outstanding, ready to accept
// REQ   | mem_req asserted, waiting for mem_ack
// RESP  | writeback pulse; may accept the next op
// EXC   | exception pulse, no memory access
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_read_write,
  input  logic [2:0]          i_funct3,
  input  logic [XLEN-1:0]     i_addr,
  input  logic [XLEN-1:0]     i_store_data,
  input  logic [4:0]          i_rd,
  load_store_unit_if.master   mem,
  output logic                o_wb_valid,
  output logic                o_wb_we,
  output logic [4:0]          o_wb_rd,
  output logic [XLEN-1:0]     o_wb_data,
  output logic                o_exc_valid,
  output logic [3:0]          o_exc_cause,
  output logic [XLEN-1:0]     o_exc_tval
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            rw_q, rw_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      cause_q, cause_d;

  logic       chk_legal, chk_misaligned;
  logic [3:0] chk_cause;
  logic       accept;

  lsu_access_check u_check (
    .funct3     (i_funct3),
    .read_write (i_read_write),
    .addr_lo    (i_addr[1:0]),
    .legal      (chk_legal),
    .misaligned (chk_misaligned),
    .cause      (chk_cause)
  );

  assign o_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    rw_d     = rw_q;
    rd_d     = rd_q;
    cause_d  = cause_q;

    case (state_q)
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_d = ST_RESP;
          rdata_d = rw_q ? '0 : mem.mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the RESP->IDLE exit so ops can issue every 2 cycles.
    if (accept) begin
      addr_d   = i_addr;
      wdata_d  = i_store_data;
      funct3_d = i_funct3;
      rw_d     = i_read_write;
      rd_d     = i_rd;
      cause_d  = chk_cause;
      state_d  = (!chk_legal || chk_misaligned) ? ST_EXC : ST_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      rw_q     <= 1'b0;
      rd_q     <= '0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      rw_q     <= rw_d;
      rd_q     <= rd_d;
      cause_q  <= cause_d;
    end
  end

  assign mem.mem_req        = (state_q == ST_REQ);
  assign mem.mem_addr       = addr_q;
  assign mem.mem_wdata      = wdata_q;
  assign mem.mem_funct3     = funct3_q;
  assign mem.mem_read_write = rw_q;

  assign o_wb_valid  = (state_q == ST_RESP);
  assign o_wb_we     = (state_q == ST_RESP) && !rw_q && (rd_q != 5'd0);
  assign o_wb_rd     = rd_q;
  assign o_wb_data   = rdata_q;
  assign o_exc_valid = (state_q == ST_EXC);
  assign o_exc_cause = cause_q;
  assign o_exc_tval  = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        rst_n, valid, rw;
  logic [2:0]  f3;
  logic [31:0] addr, sdata;
  logic [4:0]  rd;
  logic        ready, wb_valid, wb_we, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_tval;
  logic [3:0]  exc_cause;

  load_store_unit_if mem_if ();

  load_store_unit dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_read_write (rw),
    .i_funct3     (f3),
    .i_addr       (addr),
    .i_store_data (sdata),
    .i_rd         (rd),
    .mem          (mem_if),
    .o_wb_valid   (wb_valid),
    .o_wb_we      (wb_we),
    .o_wb_rd      (wb_rd),
    .o_wb_data    (wb_data),
    .o_exc_valid  (exc_valid),
    .o_exc_cause  (exc_cause),
    .o_exc_tval   (exc_tval)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expected timeline, filled in when an op is accepted.
  bit          e_req[NC], e_wb[NC], e_exc[NC], e_ready[NC], e_we[NC], e_ack[NC], e_rw[NC];
  logic [31:0] e_addr[NC], e_wdata[NC], e_wbdata[NC], e_tval[NC], a_rdata[NC];
  logic [2:0]  e_f3[NC];
  logic [4:0]  e_rd[NC];
  logic [3:0]  e_cause[NC];

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit legal_f(bit w, logic [2:0] f);
    if (w) return (f == 3'd0 || f == 3'd1 || f == 3'd2);
    return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
  endfunction

  function automatic bit mis_f(logic [2:0] f, logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f == 3'd1 || f == 3'd5) return a[0];
    if (f == 3'd2) return (a[1:0] != 2'b00);
`endif
    return 1'b0;
  endfunction

  // Memory model: acks only when the timeline says so, garbage data otherwise.
  always @(negedge clk) begin
    mem_if.mem_ack   = e_ack[cyc];
    mem_if.mem_rdata = e_ack[cyc] ? a_rdata[cyc] : $urandom;
  end

  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      chk("ready", 32'(ready), 32'(e_ready[cyc]));
      chk("mem_req", 32'(mem_if.mem_req), 32'(e_req[cyc]));
      chk("wb_valid", 32'(wb_valid), 32'(e_wb[cyc]));
      chk("exc_valid", 32'(exc_valid), 32'(e_exc[cyc]));
      if (e_req[cyc]) begin
        chk("mem_addr", mem_if.mem_addr, e_addr[cyc]);
        chk("mem_wdata", mem_if.mem_wdata, e_wdata[cyc]);
        chk("mem_funct3", 32'(mem_if.mem_funct3), 32'(e_f3[cyc]));
        chk("mem_rw", 32'(mem_if.mem_read_write), 32'(e_rw[cyc]));
      end
      if (e_wb[cyc]) begin
        chk("wb_we", 32'(wb_we), 32'(e_we[cyc]));
        chk("wb_rd", 32'(wb_rd), 32'(e_rd[cyc]));
        chk("wb_data", wb_data, e_wbdata[cyc]);
      end else begin
        chk("wb_we_idle", 32'(wb_we), 32'd0);
      end
      if (e_exc[cyc]) begin
        chk("exc_cause", 32'(exc_cause), 32'(e_cause[cyc]));
        chk("exc_tval", exc_tval, e_tval[cyc]);
      end
    end
  end

  // Present an op (held while not ready), record its timeline on acceptance.
  task automatic issue(bit w, logic [2:0] f, logic [31:0] a, logic [31:0] sd,
                       logic [4:0] r, int d, logic [31:0] rdat, output int n);
    int guard = 0;
    rw = w; f3 = f; addr = a; sdata = sd; rd = r; valid = 1'b1;
    while (!e_ready[cyc] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      miscompares++;
      $display("FAIL issue_timeout cycle %0d", cyc);
    end
    n = cyc;
    if (!legal_f(w, f) || mis_f(f, a)) begin
      e_exc[n+1]   = 1'b1;
      e_ready[n+1] = 1'b0;
      e_tval[n+1]  = a;
      if (!legal_f(w, f)) e_cause[n+1] = w ? 4'd7 : 4'd5;
      else                e_cause[n+1] = w ? 4'd6 : 4'd4;
    end else begin
      for (int k = n + 1; k <= n + 1 + d; k++) begin
        e_req[k] = 1'b1; e_ready[k] = 1'b0;
        e_addr[k] = a; e_wdata[k] = sd; e_f3[k] = f; e_rw[k] = w;
      end
      e_ack[n+1+d]    = 1'b1;
      a_rdata[n+1+d]  = rdat;
      e_wb[n+2+d]     = 1'b1;
      e_we[n+2+d]     = !w && (r != 5'd0);
      e_rd[n+2+d]     = r;
      e_wbdata[n+2+d] = w ? 32'd0 : rdat;
    end
    @(negedge clk);
    valid = 1'b0;
    addr = $urandom; sdata = $urandom; f3 = 3'($urandom); rd = 5'($urandom); rw = 1'($urandom);
  endtask

  // One-cycle reset pulse: everything outstanding is dropped.
  task automatic reset_now();
    rst_n = 1'b0;
    valid = 1'b0;
    for (int k = cyc + 1; k < NC; k++) begin
      e_req[k] = 1'b0; e_wb[k] = 1'b0; e_exc[k] = 1'b0; e_ack[k] = 1'b0; e_ready[k] = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    for (int k = 0; k < NC; k++) begin
      e_req[k] = 0; e_wb[k] = 0; e_exc[k] = 0; e_ready[k] = 1; e_we[k] = 0; e_ack[k] = 0;
      e_rw[k] = 0; e_addr[k] = 0; e_wdata[k] = 0; e_wbdata[k] = 0; e_tval[k] = 0;
      a_rdata[k] = 0; e_f3[k] = 0; e_rd[k] = 0; e_cause[k] = 0;
    end
    rst_n = 1'b0; valid = 1'b0; rw = 1'b0; f3 = 3'd0; addr = 32'd0; sdata = 32'd0; rd = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("rst_mem_funct3", 32'(mem_if.mem_funct3), 32'd0);
    chk("rst_mem_rw", 32'(mem_if.mem_read_write), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc_cause", 32'(exc_cause), 32'd0);
    chk("rst_exc_tval", exc_tval, 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // LW 0x10, ack in the request cycle.
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0, 32'hDEADBEEF, n);
    chk("lw_req_n1", 32'(mem_if.mem_req), 32'd1);
    @(negedge clk);
    chk("lw_wb_valid_n2", 32'(wb_valid), 32'd1);
    chk("lw_wb_data_n2", wb_data, 32'hDEADBEEF);
    chk("lw_wb_rd_n2", 32'(wb_rd), 32'd5);
    chk("lw_wb_we_n2", 32'(wb_we), 32'd1);
    @(negedge clk);

    // Acks while idle must be ignored.
    for (int i = 1; i <= 3; i++) e_ack[cyc+i] = 1'b1;
    repeat (4) @(negedge clk);

    // SB 0x13, ack after 3 wait cycles.
    issue(1'b1, 3'b000, 32'h13, 32'hAA, 5'd7, 3, 32'h12345678, n);
    repeat (3) @(negedge clk);
    chk("sb_req_n4", 32'(mem_if.mem_req), 32'd1);
    chk("sb_addr_n4", mem_if.mem_addr, 32'h13);
    @(negedge clk);
    chk("sb_wb_valid_n5", 32'(wb_valid), 32'd1);
    chk("sb_wb_we_n5", 32'(wb_we), 32'd0);
    chk("sb_wb_data_n5", wb_data, 32'd0);
    @(negedge clk);

    // LW to a misaligned word address.
    issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd3, 0, 32'hCAFEF00D, n);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_exc", 32'(exc_valid), 32'd1);
    chk("lw_mis_cause", 32'(exc_cause), 32'd4);
    chk("lw_mis_tval", exc_tval, 32'h102);
    chk("lw_mis_noreq", 32'(mem_if.mem_req), 32'd0);
`else
    chk("lw_mis_req", 32'(mem_if.mem_req), 32'd1);
    chk("lw_mis_addr", mem_if.mem_addr, 32'h102);
`endif
    repeat (2) @(negedge clk);

    // Illegal widths.
    issue(1'b0, 3'b011, 32'h20, 32'h0, 5'd4, 0, 32'h0, n);
    chk("ld011_exc", 32'(exc_valid), 32'd1);
    chk("ld011_cause", 32'(exc_cause), 32'd5);
    chk("ld011_noreq", 32'(mem_if.mem_req), 32'd0);
    issue(1'b1, 3'b100, 32'h24, 32'h55, 5'd0, 0, 32'h0, n);
    chk("st100_cause", 32'(exc_cause), 32'd7);
    chk("st100_tval", exc_tval, 32'h24);

    // Misaligned store halfword, illegal-width-plus-misaligned, LHU and LB to x0.
    issue(1'b1, 3'b001, 32'h31, 32'hBEEF, 5'd0, 1, 32'h0, n);
    issue(1'b1, 3'b110, 32'h33, 32'h1, 5'd0, 0, 32'h0, n);
    chk("st110_cause", 32'(exc_cause), 32'd7);
    issue(1'b0, 3'b101, 32'h43, 32'h0, 5'd9, 2, 32'h0000FFFF, n);
    issue(1'b0, 3'b000, 32'h44, 32'h0, 5'd0, 1, 32'hFFFFFF80, n);
    repeat (4) @(negedge clk);

    // Back-to-back: LW then SW presented immediately, SW interrupted by reset.
    issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd12, 0, 32'h0BADF00D, n);
    issue(1'b1, 3'b010, 32'h204, 32'h11223344, 5'd0, 5, 32'h0, n);
    chk("sw_req", 32'(mem_if.mem_req), 32'd1);
    chk("sw_addr", mem_if.mem_addr, 32'h204);
    chk("sw_wdata", mem_if.mem_wdata, 32'h11223344);
    @(negedge clk);
    reset_now();
    chk("rst_mid_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mid_wb", 32'(wb_valid), 32'd0);
    repeat (8) @(negedge clk);

    // Normal operation after reset, with an illegal op accepted in RESP.
    issue(1'b0, 3'b100, 32'h301, 32'h0, 5'd31, 0, 32'h000000EE, n);
    issue(1'b0, 3'b111, 32'h305, 32'h0, 5'd1, 0, 32'h0, n);
    repeat (4) @(negedge clk);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the RV32I_Zicsr core. It accepts one load or store from the execute stage per transaction and checks alignment and access width. It then drives the request/acknowledge interface of data_memory and returns load data and exceptions to writeback and the CSR/trap logic. It stalls upstream while a memory transaction is outstanding.

## Interface
- XLEN, 32, data/address width (from shared header)
- clk  in  1  core clock, all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  execute stage presents a memory op
- o_ready  out  1  LSU can accept an op this cycle
- i_read_write  in  1  0 = load, 1 = store
- i_funct3  in  3  RV32I width/sign code
- i_addr  in  XLEN  effective address (ALU result)
- i_store_data  in  XLEN  rs2 value
- i_rd  in  5  load destination register
- o_mem_req  out  1  request to data_memory
- o_mem_addr  out  XLEN  registered address
- o_mem_data  out  XLEN  registered store data
- o_funct3  out  3  registered funct3
- o_read_write  out  1  registered direction
- i_mem_ack  in  1  data_memory acknowledge (combinational from o_mem_req)
- i_mem_data  in  XLEN  load data, already width-extended by memory
- o_wb_valid  out  1  one-cycle completion pulse
- o_wb_we  out  1  register write enable (load, rd != 0)
- o_wb_rd  out  5  destination register
- o_wb_data  out  XLEN  captured load data (0 for stores)
- o_exc_valid  out  1  one-cycle exception pulse
- o_exc_cause  out  4  mcause code: 4/5/6/7
- o_exc_tval  out  XLEN  faulting address

## Operation
- FSM states: IDLE, REQ, RESP, EXC.
- Accept = i_valid && o_ready. o_ready is 1 in IDLE and RESP, 0 in REQ and EXC.
- On accept:
  - Latch address, store data, funct3, direction and rd.
  - Legal loads: funct3 000, 001, 010, 100, 101.
  - Legal stores: funct3 000, 001, 010.
  - Illegal width goes to EXC with cause 5 (load) or 7 (store).
  - Otherwise go to REQ.
- REQ:
  - o_mem_req = 1 and all o_mem_* held stable.
  - On i_mem_ack sampled high, capture i_mem_data (loads only) and go to RESP.
  - No timeout; the LSU waits indefinitely.
- RESP:
  - o_wb_valid = 1 for exactly one cycle.
  - o_wb_we = load && rd != 0.
  - Exit to REQ/EXC if a new op is accepted, else to IDLE.
- EXC:
  - o_exc_valid = 1 for one cycle with cause and tval = latched address.
  - No memory request is issued, no writeback occurs.
  - Return to IDLE.
- o_wb_data for stores is 0.

## Timing
- Reset values: FSM IDLE; o_mem_req = 0; o_wb_valid = 0; o_wb_we = 0; o_exc_valid = 0; o_ready = 1; every data/address output = 0.
- Load/store latency:
  - accept at cycle N, o_mem_req at N+1.
  - With ack at N+1, o_wb_valid at N+2.
  - Each extra ack-wait cycle adds one.
- Exception latency: accept at N, o_exc_valid at N+1.
- Throughput: one op per 2 cycles. An op accepted during RESP starts REQ the next cycle.
- i_mem_ack outside REQ is ignored.
- Reset asserted in any state takes effect at the next edge:
  - o_mem_req drops the cycle after.
  - A pending writeback or exception is discarded, with no pulse emitted.
  - A store already acknowledged is not undone.
- i_valid while o_ready = 0: the op is not accepted. Upstream must hold it.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - halfword with addr[0] != 0, or word with addr[1:0] != 0, goes to EXC.
  - Cause is 4 (load) or 6 (store), tval = address.
  - Illegal-width check takes priority over the misalignment check.
- Undefined: no alignment check. The request is issued with the address unchanged and data_memory's alignment behaviour applies.

## Structure
- Shared package/header holds:
  - XLEN
  - funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - mcause constants (LOAD_MISALIGNED = 4, LOAD_ACCESS_FAULT = 5, STORE_MISALIGNED = 6, STORE_ACCESS_FAULT = 7)
  - FSM state encoding
- One combinational sub-module, lsu_access_check: inputs funct3, read_write and addr[1:0]; outputs legal, misaligned and cause. Its misalignment output is gated by LSU_MISALIGN_TRAP_EN.

## Test plan
- Reset: hold i_rst_n = 0 for 2 cycles -> all outputs at reset values and o_ready = 1.
- LW, addr 0x10, memory word 0xDEADBEEF, ack same cycle as req -> o_mem_req at N+1; o_wb_valid at N+2 with o_wb_data = 0xDEADBEEF, o_wb_rd = latched rd, o_wb_we = 1.
- SB, addr 0x13, data 0x000000AA, ack delayed 3 cycles -> o_mem_req held 4 cycles with stable addr/data/funct3 = 000; then o_wb_valid with o_wb_we = 0 and o_ready = 0 throughout REQ.
- LW, addr 0x0000_0102:
  - with LSU_MISALIGN_TRAP_EN -> no o_mem_req; o_exc_valid at N+1, cause 4, tval 0x102.
  - without it -> normal request to 0x102.
- Load with funct3 = 011 -> o_exc_valid, cause 5, no request. Store with funct3 = 100 -> cause 7.
- Back-to-back: LW accepted at N, SW presented in RESP at N+2 -> SW accepted at N+2, o_mem_req at N+3. Reset asserted during SW's REQ -> o_mem_req = 0 next cycle, no o_wb_valid pulse.
